// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: 2-flop sync, debounce, press pulse.
// Each channel is independent; ANY_P is the OR of the next-cycle pulses.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic CLOCK,
  input  logic CPU_RESETN,
  input  logic BTNC,
  input  logic BTNU,
  input  logic BTND,
  input  logic BTNL,
  input  logic BTNR,
  output logic BTNC_P,
  output logic BTNU_P,
  output logic BTND_P,
  output logic BTNL_P,
  output logic BTNR_P,
  output logic BTNC_L,
  output logic BTNU_L,
  output logic BTND_L,
  output logic BTNL_L,
  output logic BTNR_L,
  output logic ANY_P
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0] raw;
  logic [4:0] stable;
  logic [4:0] pulse;
  logic [4:0] pulse_nxt;
  logic       any_q;
  logic       any_d;

  assign raw = {BTNR, BTNL, BTND, BTNU, BTNC};

  for (genvar i = 0; i < 5; i++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count only while the synced input disagrees; flip at terminal count.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      pulse_d  = 1'b0;
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_MAX) begin
          stable_d = sync2_q;
          pulse_d  = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
      end else begin
        sync1_q  <= raw[i];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
      end
    end

    assign stable[i]    = stable_q;
    assign pulse[i]     = pulse_q;
    assign pulse_nxt[i] = pulse_d;
  end

  assign any_d = |pulse_nxt;

  always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign BTNC_P = pulse[0];
  assign BTNU_P = pulse[1];
  assign BTND_P = pulse[2];
  assign BTNL_P = pulse[3];
  assign BTNR_P = pulse[4];
  assign BTNC_L = stable[0];
  assign BTNU_L = stable[1];
  assign BTND_L = stable[2];
  assign BTNL_L = stable[3];
  assign BTNR_L = stable[4];
  assign ANY_P  = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with DEBOUNCE_CYCLES = 4.
// Reference model: a press/release is accepted once D consecutive synced samples disagree.
module tb_btn_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] p;
  logic [4:0] l;
  logic       anyp;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_l;
  logic [4:0] m_p;
  logic       m_any;
  logic       rh[5][$];
  logic       sh[5][$];

  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK(clk),
    .CPU_RESETN(rst_n),
    .BTNC(btn[0]),
    .BTNU(btn[1]),
    .BTND(btn[2]),
    .BTNL(btn[3]),
    .BTNR(btn[4]),
    .BTNC_P(p[0]),
    .BTNU_P(p[1]),
    .BTND_P(p[2]),
    .BTNL_P(p[3]),
    .BTNR_P(p[4]),
    .BTNC_L(l[0]),
    .BTNU_L(l[1]),
    .BTND_L(l[2]),
    .BTNL_L(l[3]),
    .BTNR_L(l[4]),
    .ANY_P(anyp)
  );

  always #5 clk = ~clk;

  // Synced value seen at edge k is the raw sample from edge k-2.
  always @(posedge clk or negedge rst_n) begin : model
    logic [4:0] np;
    logic       s2;
    logic       flip;
    if (!rst_n) begin
      m_l   = '0;
      m_p   = '0;
      m_any = 1'b0;
      for (int c = 0; c < 5; c++) begin
        rh[c].delete();
        sh[c].delete();
      end
    end else begin
      np = '0;
      for (int c = 0; c < 5; c++) begin
        s2 = (rh[c].size() >= 2) ? rh[c][rh[c].size()-2] : 1'b0;
        rh[c].push_back(btn[c]);
        if (rh[c].size() > 4) void'(rh[c].pop_front());
        sh[c].push_back(s2);
        if (sh[c].size() > D) void'(sh[c].pop_front());
        flip = (sh[c].size() == D);
        foreach (sh[c][k]) if (sh[c][k] == m_l[c]) flip = 1'b0;
        if (flip) begin
          m_l[c] = ~m_l[c];
          np[c]  = m_l[c];
        end
      end
      m_p   = np;
      m_any = |np;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int np;
    btn   = 5'h1f;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({anyp, p, l} !== 11'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp 000", {anyp, p, l});
    end
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++;
      if ({anyp, p, l} !== 11'h0) begin
        errors++;
        $display("FAIL reset_hold got %h exp 000", {anyp, p, l});
      end
    end
    rst_n = 1'b1;
    np = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      np += int'(anyp);
      checks++;
      if ({anyp, p, l} !== {(n == 5), (n == 5) ? 5'h1f : 5'h0,
                            (n >= 5) ? 5'h1f : 5'h0}) begin
        errors++;
        $display("FAIL reset_release n=%0d got %h", n, {anyp, p, l});
      end
      checks++;
      if ({anyp, p, l} !== {m_any, m_p, m_l}) begin
        errors++;
        $display("FAIL reset_model got %h exp %h", {anyp, p, l}, {m_any, m_p, m_l});
      end
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL reset_pulse_count got %0d exp 1", np);
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  task automatic test_clean_press();
    int np;
    np     = 0;
    btn[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cyc();
      np += int'(p[1]);
      checks++;
      if ({anyp, p[1], l[1]} !== {(n == 5), (n == 5), (n >= 5)}) begin
        errors++;
        $display("FAIL clean_press n=%0d got %b", n, {anyp, p[1], l[1]});
      end
      checks++;
      if ({anyp, p, l} !== {m_any, m_p, m_l}) begin
        errors++;
        $display("FAIL clean_model got %h exp %h", {anyp, p, l}, {m_any, m_p, m_l});
      end
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL clean_pulse_count got %0d exp 1", np);
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int np;
    np  = 0;
    pat = 6'b011011;
    for (int n = 0; n < 16; n++) begin
      btn[3] = (n < 6) ? pat[n] : 1'b0;
      cyc();
      np += int'(p[3]);
      checks++;
      if (l[3] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level n=%0d got %b exp 0", n, l[3]);
      end
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL bounce_pulse_count got %0d exp 0", np);
    end
    btn[3] = 1'b1;
    for (int n = 0; n < 14; n++) begin
      cyc();
      np += int'(p[3]);
      checks++;
      if ({anyp, p, l} !== {m_any, m_p, m_l}) begin
        errors++;
        $display("FAIL bounce_model got %h exp %h", {anyp, p, l}, {m_any, m_p, m_l});
      end
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL bounce_steady_count got %0d exp 1", np);
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  task automatic test_release_repress();
    int np;
    np = 0;
    for (int ph = 0; ph < 4; ph++) begin
      btn[4] = (ph == 0 || ph == 2);
      for (int n = 0; n < 10; n++) begin
        cyc();
        np += int'(p[4]);
        if (ph == 1) begin
          checks++;
          if (l[4] !== (n < 5)) begin
            errors++;
            $display("FAIL release_level n=%0d got %b exp %b", n, l[4], (n < 5));
          end
        end
        checks++;
        if ({anyp, p, l} !== {m_any, m_p, m_l}) begin
          errors++;
          $display("FAIL repress_model got %h exp %h", {anyp, p, l}, {m_any, m_p, m_l});
        end
      end
    end
    checks++;
    if (np != 2) begin
      errors++;
      $display("FAIL repress_pulse_count got %0d exp 2", np);
    end
  endtask

  task automatic test_simultaneous();
    btn = 5'b00101;
    for (int n = 0; n < 10; n++) begin
      cyc();
      checks++;
      if ({anyp, p} !== ((n == 5) ? 6'b100101 : 6'b000000)) begin
        errors++;
        $display("FAIL simul n=%0d got %b", n, {anyp, p});
      end
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  task automatic test_reset_mid();
    btn[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      checks++;
      if ({anyp, p} !== 6'b0) begin
        errors++;
        $display("FAIL mid_prereset n=%0d got %b exp 0", n, {anyp, p});
      end
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({anyp, p, l} !== 11'h0) begin
      errors++;
      $display("FAIL mid_reset got %h exp 000", {anyp, p, l});
    end
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      checks++;
      if ({anyp, p} !== ((n == 5) ? 6'b100001 : 6'b000000)) begin
        errors++;
        $display("FAIL mid_release n=%0d got %b", n, {anyp, p});
      end
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 150; s++) begin
      btn = 5'($urandom);
      len = int'($urandom_range(1, 8));
      for (int n = 0; n < len; n++) begin
        cyc();
        checks++;
        if ({anyp, p, l} !== {m_any, m_p, m_l}) begin
          errors++;
          $display("FAIL random_model got %h exp %h", {anyp, p, l}, {m_any, m_p, m_l});
        end
      end
    end
    btn = '0;
    repeat (10) cyc();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_repress();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
